// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST dense-layer datapath: MAC pipeline depth,
// sequencer states and the signed 8-bit saturation used on accumulator results.
package mnist_pkg;

    // Buffer read + MAC operand register + multiplier register.
    localparam int unsigned MAC_LAT = 3;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFeed,
        StDrain,
        StRelu,
        StCapt,
        StDone
    } ctrl_state_e;

    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        logic signed [7:0] r;
        if (v > 32'sd127) begin
            r = 8'sd127;
        end else if (v < -32'sd128) begin
            r = 8'sh80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/quant_sat.sv
// Combinational requantiser: arithmetic right shift of a 32-bit accumulator
// followed by saturation to signed 8 bits.
module quant_sat
    import mnist_pkg::*;
#(
    parameter int unsigned SHIFT = 8
) (
    input  logic signed [31:0] i_acc,
    output logic signed [7:0]  o_q
);

    logic signed [31:0] w_shifted;

    assign w_shifted = i_acc >>> SHIFT;
    assign o_q       = sat8(w_shifted);

endmodule

// File: rtl/mac_ctrl.sv
// Sequencer for one MAC datapath computing a dense layer: streams buffer addresses,
// times the MAC controls to its pipeline, and hands quantised results downstream.
module mac_ctrl
    import mnist_pkg::*;
#(
    parameter int unsigned VEC_LEN    = 784,
    parameter int unsigned NUM_NEURON = 10,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned IADDR_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
    parameter int unsigned WADDR_W    =
        (VEC_LEN * NUM_NEURON > 1) ? $clog2(VEC_LEN * NUM_NEURON) : 1,
    localparam int unsigned IDX_W     = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                rd_en_o,
    output logic [IADDR_W-1:0]  img_addr_o,
    output logic [WADDR_W-1:0]  wgt_addr_o,
    output logic                acc_en_o,
    output logic                relu_en_o,
    output logic                mac_clear_o,
    input  logic signed [31:0]  acc_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic signed [7:0]   res_data_o,
    output logic [IDX_W-1:0]    res_idx_o
);

    localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [IADDR_W-1:0] K_LAST     = IADDR_W'(VEC_LEN - 1);
    localparam logic [IDX_W-1:0]   N_LAST     = IDX_W'(NUM_NEURON - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);

    ctrl_state_e          r_state;
    logic [IADDR_W-1:0]   r_k;
    logic [WADDR_W-1:0]   r_waddr;
    logic [IDX_W-1:0]     r_n;
    logic [DRAIN_W-1:0]   r_drain;
    logic                 r_rd_en;
    logic                 r_relu_en;
    logic                 r_busy;
    logic                 r_done;
    logic [MAC_LAT-1:0]   r_acc_dly;
    logic                 r_res_valid;
    logic signed [7:0]    r_res_data;
    logic [IDX_W-1:0]     r_res_idx;

    logic                 w_res_free;
    logic                 w_capture;
    logic signed [7:0]    w_quant;

    quant_sat #(
        .SHIFT (SHIFT)
    ) u_quant (
        .i_acc (acc_i),
        .o_q   (w_quant)
    );

    // Result slot can take a new value if empty or being drained this very cycle.
    assign w_res_free = !r_res_valid || res_ready_i;
    assign w_capture  = (r_state == StCapt) && w_res_free;

    // Clear on capture must follow res_ready_i in the same cycle, so it stays combinational.
    assign mac_clear_o = (r_state == StClr) || w_capture;

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign rd_en_o     = r_rd_en;
    assign img_addr_o  = r_k;
    assign wgt_addr_o  = r_waddr;
    assign relu_en_o   = r_relu_en;
    assign acc_en_o    = r_acc_dly[MAC_LAT-1];
    assign res_valid_o = r_res_valid;
    assign res_data_o  = r_res_data;
    assign res_idx_o   = r_res_idx;

    // Accumulate enable tracks read data through the MAC pipeline, regardless of state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc_dly <= '0;
        end else if (MAC_LAT > 1) begin
            r_acc_dly <= {r_acc_dly[MAC_LAT-2:0], r_rd_en};
        end else begin
            r_acc_dly <= r_rd_en;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_idx   <= '0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_quant;
            r_res_idx   <= r_n;
        end else if (r_res_valid && res_ready_i) begin
            r_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_k       <= '0;
            r_waddr   <= '0;
            r_n       <= '0;
            r_drain   <= '0;
            r_rd_en   <= 1'b0;
            r_relu_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_state <= StClr;
                        r_busy  <= 1'b1;
                    end
                end
                StClr: begin
                    r_state <= StFeed;
                    r_rd_en <= 1'b1;
                    r_k     <= '0;
                    r_waddr <= '0;
                    r_n     <= '0;
                end
                StFeed: begin
                    if (r_k == K_LAST) begin
                        r_state <= StDrain;
                        r_rd_en <= 1'b0;
                        r_drain <= '0;
                    end else begin
                        r_k     <= r_k + IADDR_W'(1);
                        r_waddr <= r_waddr + WADDR_W'(1);
                    end
                end
                StDrain: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state   <= StRelu;
                        r_relu_en <= 1'b1;
                    end else begin
                        r_drain <= r_drain + DRAIN_W'(1);
                    end
                end
                StRelu: begin
                    r_relu_en <= 1'b0;
                    r_state   <= StCapt;
                end
                StCapt: begin
                    if (w_res_free) begin
                        if (r_n == N_LAST) begin
                            r_state <= StDone;
                        end else begin
                            r_state <= StFeed;
                            r_n     <= r_n + IDX_W'(1);
                            r_k     <= '0;
                            r_waddr <= r_waddr + WADDR_W'(1);
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (w_res_free) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_ctrl.sv
// Bench for mac_ctrl: a buffer + MAC pipeline environment feeds acc_i, and every
// result is compared with a dot product computed directly from the memory contents.
module tb_mac_ctrl;

    localparam int L  = 4;
    localparam int N  = 2;
    localparam int SH = 0;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              busy_o;
    logic              done_o;
    logic              rd_en_o;
    logic [1:0]        img_addr_o;
    logic [2:0]        wgt_addr_o;
    logic              acc_en_o;
    logic              relu_en_o;
    logic              mac_clear_o;
    logic signed [31:0] acc_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic signed [7:0] res_data_o;
    logic [0:0]        res_idx_o;

    logic signed [31:0] qs_in;
    logic signed [7:0]  qs_out;

    int checks   = 0;
    int failures = 0;

    mac_ctrl #(
        .VEC_LEN    (L),
        .NUM_NEURON (N),
        .SHIFT      (SH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .img_addr_o  (img_addr_o),
        .wgt_addr_o  (wgt_addr_o),
        .acc_en_o    (acc_en_o),
        .relu_en_o   (relu_en_o),
        .mac_clear_o (mac_clear_o),
        .acc_i       (acc_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_idx_o   (res_idx_o)
    );

    quant_sat #(
        .SHIFT (7)
    ) u_qs (
        .i_acc (qs_in),
        .o_q   (qs_out)
    );

    always #5 clk = ~clk;

    // Environment: image/weight buffers (1-cycle read) and a MAC with op + mul registers.
    int img_mem [L];
    int wgt_mem [L*N];
    logic signed [31:0] buf_a, buf_b, op_a, op_b, mul_q, mac_acc;
    assign acc_i = mac_acc;

    always @(posedge clk) begin
        if (rst_i) begin
            buf_a   <= '0;
            buf_b   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            mul_q   <= '0;
            mac_acc <= '0;
        end else begin
            if (rd_en_o) begin
                buf_a <= img_mem[img_addr_o];
                buf_b <= wgt_mem[wgt_addr_o];
            end
            op_a  <= buf_a;
            op_b  <= buf_b;
            mul_q <= op_a * op_b;
            if (acc_en_o) mac_acc <= mac_acc + mul_q;
            else if (relu_en_o) begin
                if (mac_acc < 0) mac_acc <= '0;
            end else if (mac_clear_o) mac_acc <= '0;
        end
    end

    // Reference: quantise by plain arithmetic.
    function automatic int ref_quant(input longint v, input int sh);
        longint r;
        r = v >>> sh;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    function automatic int ref_result(input int n);
        longint sum;
        sum = 0;
        for (int k = 0; k < L; k++) sum += longint'(img_mem[k]) * longint'(wgt_mem[n*L + k]);
        if (sum < 0) sum = 0;
        return ref_quant(sum, SH);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Monitor: samples on the falling edge; rel is the cycle index relative to start.
    int cyc = 0;
    int t0  = 0;
    logic signed [7:0] got_data [$];
    int got_idx [$];
    int acc_q [$];
    int clear_q [$];
    int relu_q [$];
    int rd_q [$];
    int done_cnt, done_rel, hold_err, overlap_err;
    logic busy_at1, busy_after;
    logic p_valid, p_ready;
    logic signed [7:0] p_data;
    int p_idx;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        p_valid = 1'b0;
        p_ready = 1'b1;
        forever begin
            int rel;
            @(negedge clk);
            rel = cyc - t0;
            if (res_valid_o && res_ready_i) begin
                got_data.push_back(res_data_o);
                got_idx.push_back(int'(res_idx_o));
            end
            if (done_o) begin
                done_cnt++;
                done_rel = rel;
            end
            if (acc_en_o) acc_q.push_back(rel);
            if (mac_clear_o) clear_q.push_back(rel);
            if (relu_en_o) relu_q.push_back(rel);
            if (rd_en_o) rd_q.push_back(rel);
            if (rel == 1) busy_at1 = busy_o;
            if (done_cnt != 0 && rel == done_rel + 1) busy_after = busy_o;
            if (int'(acc_en_o) + int'(relu_en_o) + int'(mac_clear_o) > 1) overlap_err++;
            if (p_valid && !p_ready &&
                !(res_valid_o && res_data_o == p_data && int'(res_idx_o) == p_idx)) hold_err++;
            p_valid = res_valid_o;
            p_ready = res_ready_i;
            p_data  = res_data_o;
            p_idx   = int'(res_idx_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_idx.delete();
        acc_q.delete();
        clear_q.delete();
        relu_q.delete();
        rd_q.delete();
        done_cnt    = 0;
        done_rel    = 0;
        hold_err    = 0;
        overlap_err = 0;
        busy_at1    = 1'b0;
        busy_after  = 1'b1;
    endtask

    task automatic fill_mem(input int img_lo, input int img_hi, input int w_mag);
        for (int k = 0; k < L; k++) img_mem[k] = int'($urandom_range(img_hi - img_lo)) + img_lo;
        for (int i = 0; i < L*N; i++) wgt_mem[i] = int'($urandom_range(2*w_mag)) - w_mag;
    endtask

    // mode 0: always ready; 1: ready low for rel 11..30; 2: random ready.
    task automatic run_layer(input string name, input int mode, input bit extra_starts);
        int rel;
        clear_mon();
        start_i     = 1'b1;
        res_ready_i = 1'b1;
        t0          = cyc;
        for (int i = 0; i < 400; i++) begin
            tick();
            rel     = cyc - t0;
            start_i = extra_starts && (rel == 5 || rel == 12 || rel == 20);
            case (mode)
                0:       res_ready_i = 1'b1;
                1:       res_ready_i = !(rel >= 11 && rel <= 30);
                default: res_ready_i = ($urandom_range(3) != 0);
            endcase
            if (done_cnt != 0 && rel > done_rel + 4) break;
        end
        start_i     = 1'b0;
        res_ready_i = 1'b1;
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_result_count"}, got_data.size(), N);
        for (int n = 0; n < N && n < got_data.size(); n++) begin
            chk($sformatf("%s_idx%0d", name, n), got_idx[n], n);
            chk($sformatf("%s_data%0d", name, n), got_data[n], ref_result(n));
        end
        chk({name, "_hold_stable"}, hold_err, 0);
        chk({name, "_ctrl_overlap"}, overlap_err, 0);
        chk({name, "_busy_cycle1"}, busy_at1, 1);
        chk({name, "_busy_after_done"}, busy_after, 0);
        chk({name, "_idle_after"}, busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_stall;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        res_ready_i = 1'b1;
        qs_in       = '0;
        for (int k = 0; k < L; k++) img_mem[k] = 0;
        for (int i = 0; i < L*N; i++) wgt_mem[i] = 0;
        clear_mon();
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd_en", rd_en_o, 0);
        chk("rst_acc_en", acc_en_o, 0);
        chk("rst_relu_en", relu_en_o, 0);
        chk("rst_clear", mac_clear_o, 0);
        chk("rst_valid", res_valid_o, 0);
        chk("rst_data", res_data_o, 0);
        rst_i = 1'b0;
        tick();

        // Unit weights, image 1..4: both neurons give 10; check pipeline timing.
        for (int k = 0; k < L; k++) img_mem[k] = k + 1;
        for (int i = 0; i < L*N; i++) wgt_mem[i] = 1;
        run_layer("ones", 0, 1'b0);
        if (got_data.size() == N) begin
            chk("ones_const0", got_data[0], 10);
            chk("ones_const1", got_data[1], 10);
        end
        chk("ones_done_cycle", done_rel, 21);
        chk("ones_rd_count", rd_q.size(), 2*L);
        if (rd_q.size() > 0) chk("ones_rd_first", rd_q[0], 2);
        chk("ones_acc_count", acc_q.size(), 2*L);
        if (acc_q.size() >= 5) begin
            chk("ones_acc_first", acc_q[0], 5);
            chk("ones_acc_last_n0", acc_q[3], 8);
            chk("ones_acc_first_n1", acc_q[4], 14);
        end
        if (relu_q.size() > 0) chk("ones_relu_cycle", relu_q[0], 9);
        chk("ones_clear_count", clear_q.size(), 3);
        if (clear_q.size() >= 2) begin
            chk("ones_clear_clr", clear_q[0], 1);
            chk("ones_clear_capt", clear_q[1], 10);
        end

        // Negative sums are removed by ReLU.
        for (int i = 0; i < L*N; i++) wgt_mem[i] = -1;
        run_layer("neg", 0, 1'b0);
        if (got_data.size() == N) chk("neg_const0", got_data[0], 0);

        // Sum 1000 with SHIFT=0 saturates to 127.
        for (int i = 0; i < L*N; i++) wgt_mem[i] = 100;
        run_layer("sat", 0, 1'b0);
        if (got_data.size() == N) chk("sat_const0", got_data[0], 127);

        // Quantiser with SHIFT=7 at the clamp boundary and extremes.
        qs_in = 32'h0000_3F80; #1; chk("qs_3f80", qs_out, 127);
        qs_in = 32'h0000_3F7F; #1; chk("qs_3f7f", qs_out, 126);
        qs_in = 32'h7FFF_FFFF; #1; chk("qs_maxpos", qs_out, 127);
        qs_in = 32'h8000_0000; #1; chk("qs_maxneg", qs_out, -128);
        qs_in = 32'hFFFF_C000; #1; chk("qs_neg128", qs_out, -128);
        qs_in = 32'hFFFF_BF80; #1; chk("qs_neg129", qs_out, -128);
        for (int i = 0; i < 8; i++) begin
            qs_in = $signed(32'($urandom_range(65535)) - 32'd32768);
            #1;
            chk("qs_random", qs_out, ref_quant(longint'(qs_in), 7));
        end

        // Back-pressure: result 0 not accepted for 20 cycles; FSM must wait in CAPT.
        fill_mem(0, 7, 4);
        run_layer("stall", 1, 1'b0);
        n_stall = 0;
        foreach (acc_q[i]) if (acc_q[i] >= 18 && acc_q[i] <= 31) n_stall++;
        chk("stall_no_acc_en", n_stall, 0);
        chk("stall_clear_count", clear_q.size(), 3);
        if (clear_q.size() == 3) chk("stall_capture_cycle", clear_q[2], 31);
        chk("stall_done_cycle", done_rel, 33);

        // Reset on the second FEED cycle, then a fresh layer.
        fill_mem(0, 7, 4);
        clear_mon();
        start_i = 1'b1;
        t0      = cyc;
        tick();
        start_i = 1'b0;
        repeat (2) tick();
        chk("midrst_feeding", rd_en_o, 1);
        chk("midrst_addr", img_addr_o, 1);
        rst_i = 1'b1;
        tick();
        chk("midrst_busy", busy_o, 0);
        chk("midrst_rd_en", rd_en_o, 0);
        chk("midrst_acc_en", acc_en_o, 0);
        chk("midrst_relu", relu_en_o, 0);
        chk("midrst_clear", mac_clear_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_valid", res_valid_o, 0);
        chk("midrst_data", res_data_o, 0);
        chk("midrst_idx", res_idx_o, 0);
        chk("midrst_img_addr", img_addr_o, 0);
        chk("midrst_wgt_addr", wgt_addr_o, 0);
        rst_i = 1'b0;
        repeat (2) tick();
        chk("midrst_stays_idle", busy_o, 0);
        chk("midrst_no_result", got_data.size(), 0);
        run_layer("after_rst", 0, 1'b0);

        // start_i while busy is ignored.
        fill_mem(0, 7, 4);
        run_layer("restart", 0, 1'b1);

        // Random layers with random back-pressure, small and large magnitudes.
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) fill_mem(0, 7, 4);
            else fill_mem(0, 255, 128);
            run_layer($sformatf("rand%0d", r), 2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Sequencer that drives one MAC datapath through a dense-layer dot product. For each neuron it issues buffer read addresses, raises `acc_en_o`/`relu_en_o`/`mac_clear_o` aligned to the MAC's internal pipeline, then captures the 32-bit accumulator. It quantises the captured value to signed 8 bits and hands it downstream over valid/ready. It sits between the image/weight buffers and the next layer's input buffer, on the control side of the MAC.

## Interface
- `VEC_LEN`, 784: elements per dot product (L); legal range ≥1.
- `NUM_NEURON`, 10: neurons per layer (N); legal range ≥1.
- `SHIFT`, 8: arithmetic right shift applied before saturation.
- `IADDR_W`, `$clog2(VEC_LEN)`: image address width.
- `WADDR_W`, `$clog2(VEC_LEN*NUM_NEURON)`: weight address width.
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: one-cycle pulse; begins a layer when idle.
- `busy_o` out 1: high from the cycle after an accepted start until `done_o`.
- `done_o` out 1: one-cycle pulse after the last result handshake.
- `rd_en_o` out 1: buffer read strobe; data is returned 1 cycle later straight to the MAC inputs.
- `img_addr_o` out IADDR_W: image element index k.
- `wgt_addr_o` out WADDR_W: n*L + k.
- `acc_en_o`, `relu_en_o`, `mac_clear_o` out 1 each: MAC controls.
- `acc_i` in 32 signed: MAC accumulator output.
- `res_valid_o` out 1, `res_ready_i` in 1: result handshake.
- `res_data_o` out 8 signed: quantised result.
- `res_idx_o` out `$clog2(NUM_NEURON)`: neuron index n of `res_data_o`.

## Operation
- FSM states: IDLE, CLR, FEED, DRAIN, RELU, CAPT, DONE.
- IDLE -> CLR on `start_i`. `start_i` is ignored in every other state.
- CLR: `mac_clear_o`=1 for 1 cycle; n=0, k=0; -> FEED.
- FEED: `rd_en_o`=1 for L consecutive cycles, k=0..L-1; -> DRAIN after k=L-1.
- DRAIN: 3 cycles, so the last `acc_en_o` lands; -> RELU.
- RELU: `relu_en_o`=1 for 1 cycle; -> CAPT.
- CAPT: waits until the result register is empty or being emptied this cycle (`res_valid_o` && `res_ready_i`). On the capture cycle:
  - load `res_data_o` = sat8(`acc_i` >>> SHIFT);
  - `mac_clear_o`=1;
  - then -> FEED with n+1, or -> DONE if n=N-1.
- Saturation: results above 127 become 127; results below -128 become -128. After ReLU only the 127 clamp is reachable, but both bounds are implemented.
- `acc_en_o` is a 3-cycle-delayed copy of `rd_en_o`: 1 cycle buffer read + op register + mul register. It is a shift register that is independent of the FSM state.
- The MAC gives `acc_en` priority over `relu_en` over `mac_clear`. The controller never asserts two of them in the same cycle.
- DONE: waits until the final result is accepted, then pulses `done_o`; -> IDLE.
- `rst_i`, at any time, including mid-FEED:
  - state goes to IDLE;
  - all outputs go to 0, including the delay line and the result register;
  - the MAC must be reset alongside; the controller does not clear it on reset.

## Timing
- Let F be the first FEED cycle of neuron n.
  - `rd_en_o` is high in F..F+L-1.
  - `acc_en_o` is high in F+3..F+L+2.
  - `relu_en_o` is high in F+L+3.
  - Capture and `mac_clear_o` occur in F+L+4, when unstalled.
  - `res_valid_o` is high from F+L+5.
  - The next FEED starts at F+L+5.
- Unstalled layer: start at cycle 0, CLR at cycle 1, first FEED at cycle 2. Each neuron takes L+5 cycles.
- `res_valid_o` holds, and `res_data_o`/`res_idx_o` stay stable, until `res_ready_i`.
- Back-pressure only stalls in CAPT. FEED is never interrupted, because the MAC pipeline cannot be paused.
- L=1: FEED lasts a single cycle; all relations above still hold.

## Structure
- Shared package `mnist_pkg`: MAC pipeline depth constant (`MAC_LAT`=3), the FSM state enum, and the sat8 function.
- Sub-module `quant_sat`: combinational shift plus saturate, 32 -> 8, parameterised by SHIFT. Reused by later layers.

## Test plan
- L=4, N=2, SHIFT=0, bench MAC model, all weights 1, image 1..4, `res_ready_i`=1 -> results (idx0, 10) then (idx1, 10); `acc_en_o` high exactly in cycles 5..8; `done_o` in cycle 21.
- Negative sum (weights -1, image 1..4) -> ReLU applied, `res_data_o`=0.
- Accumulator 1000 with SHIFT=0 -> 127; accumulator 0x0000_3F80 with SHIFT=7 -> 127; accumulator 0x0000_3F7F with SHIFT=7 -> 126.
- `res_ready_i` low for 20 cycles after the first result -> FSM holds in CAPT; second result is not lost; no `acc_en_o` during the stall.
- `rst_i` asserted at the 2nd FEED cycle -> next cycle all outputs 0, state IDLE; a fresh `start_i` produces correct results.
- `start_i` pulsed while busy -> ignored; exactly N results and a single `done_o`.
